// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory path: access-size codes, store/load
// direction, byte-lane masks and the response tag values.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzIll  = 2'b11
  } size_e;

  localparam logic WeLoad  = 1'b0;
  localparam logic WeStore = 1'b1;

  // Lane masks before shifting by the low address bits.
  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  localparam logic TagCpu  = 1'b0;
  localparam logic TagHost = 1'b1;

endpackage

// File: rtl/dmem_lane_gen.sv
// Byte-lane generator: turns access size and the low two address bits into
// byte enables, lane-replicated write data and a misaligned/illegal flag.
// Ports:
//   size_i       access size (byte/half/word/illegal)
//   addr_lo_i    byte address bits [1:0]
//   wdata_i      right-aligned store data
//   be_o         byte-lane enables (0 when misaligned)
//   wdata_o      store data replicated across lanes
//   misaligned_o access cannot be performed
module dmem_lane_gen
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = '0;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SzByte: begin
        be_o    = BeByte << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SzHalf: begin
        if (addr_lo_i[0]) begin
          misaligned_o = 1'b1;
        end else begin
          be_o    = BeHalf << addr_lo_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
      end
      SzWord: begin
        if (addr_lo_i != 2'b00) begin
          misaligned_o = 1'b1;
        end else begin
          be_o = BeWord;
        end
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (cpu) and a host/debug
// loader (host). Fixed priority to cpu with a starvation counter and a host
// burst lock; the winning request is converted to word index + byte lanes and
// the 1-cycle read word is routed back to the requester that issued it.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cpu_* / host_*          request (req/we/size/addr/wdata) and response
//                           (gnt/rvalid/rdata/err) per requester
//   host_lock               host keeps the grant while asserted
//   mem_en/we/be/widx/wdata memory command; mem_rdata returns next cycle
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned HOST_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_size,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_err,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [1:0]    host_size,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  output logic          host_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-3:0] mem_widx,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned WaitW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(HOST_MAX_WAIT);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             lock_q, lock_d;
  logic             rvalid_q, rvalid_d;
  logic             resp_tag_q, resp_tag_d;
  logic             cpu_err_q, cpu_err_d;
  logic             host_err_q, host_err_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      host_rdata_q, host_rdata_d;

  logic          host_win, any_gnt;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic          lane_mis;

  // Grant and winner mux. Grants are masked during reset so nothing reaches memory.
  always_comb begin
    host_win  = host_req & ((lock_q & host_lock) | (wait_q == WaitMax) | ~cpu_req);
    host_gnt  = rst_n & host_win;
    cpu_gnt   = rst_n & cpu_req & ~host_win;
    any_gnt   = cpu_gnt | host_gnt;
    sel_we    = host_gnt ? host_we    : cpu_we;
    sel_size  = host_gnt ? host_size  : cpu_size;
    sel_addr  = host_gnt ? host_addr  : cpu_addr;
    sel_wdata = host_gnt ? host_wdata : cpu_wdata;
  end

  dmem_lane_gen u_lane_gen (
    .size_i      (sel_size),
    .addr_lo_i   (sel_addr[1:0]),
    .wdata_i     (sel_wdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .misaligned_o(lane_mis)
  );

  // Misaligned requests still get gnt but never touch memory.
  always_comb begin
    mem_en    = any_gnt & ~lane_mis;
    mem_we    = mem_en & (sel_we == WeStore);
    mem_be    = mem_en ? lane_be : 4'b0000;
    mem_widx  = mem_en ? sel_addr[AW-1:2] : '0;
    mem_wdata = mem_we ? lane_wdata : 32'h0;
  end

  always_comb begin
    wait_d = wait_q;
    if (host_gnt || !host_req) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 1'b1;
    end
    lock_d       = host_gnt & host_lock;
    rvalid_d     = mem_en & (sel_we == WeLoad);
    resp_tag_d   = rvalid_d ? (host_gnt ? TagHost : TagCpu) : resp_tag_q;
    cpu_err_d    = cpu_gnt & lane_mis;
    host_err_d   = host_gnt & lane_mis;
    // Each requester's rdata holds its last returned word.
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    if (rvalid_q && (resp_tag_q == TagCpu)) cpu_rdata_d = mem_rdata;
    if (rvalid_q && (resp_tag_q == TagHost)) host_rdata_d = mem_rdata;
  end

  // Responses are masked combinationally so an access in flight at reset is dropped.
  always_comb begin
    cpu_rvalid  = rst_n & rvalid_q & (resp_tag_q == TagCpu);
    host_rvalid = rst_n & rvalid_q & (resp_tag_q == TagHost);
    cpu_err     = rst_n & cpu_err_q;
    host_err    = rst_n & host_err_q;
    cpu_rdata   = !rst_n ? 32'h0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
    host_rdata  = !rst_n ? 32'h0 : (host_rvalid ? mem_rdata : host_rdata_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q       <= '0;
      lock_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      resp_tag_q   <= TagCpu;
      cpu_err_q    <= 1'b0;
      host_err_q   <= 1'b0;
      cpu_rdata_q  <= 32'h0;
      host_rdata_q <= 32'h0;
    end else begin
      wait_q       <= wait_d;
      lock_q       <= lock_d;
      rvalid_q     <= rvalid_d;
      resp_tag_q   <= resp_tag_d;
      cpu_err_q    <= cpu_err_d;
      host_err_q   <= host_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_lock, host_gnt, host_rvalid, host_err;
  logic [1:0]  host_size;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_widx;
  logic [31:0] mem_wdata, mem_rdata;

  typedef struct {
    bit          host;
    bit          err;
    logic [31:0] data;
  } resp_t;

  resp_t       sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          cpu_known, host_known;
  logic [31:0] cpu_last, host_last;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .HOST_MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_size   (cpu_size),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_size  (host_size),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_widx   (mem_widx),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory contents are a fixed function of the word index.
  function automatic logic [31:0] mem_fn(input logic [29:0] w);
    return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
  endfunction

  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? mem_fn(mem_widx) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_size = sz; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_host(input bit req, input bit we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input bit lock);
    host_req = req; host_we = we; host_size = sz; host_addr = addr; host_wdata = wd;
    host_lock = lock;
  endtask

  task automatic check_resp(input string tag);
    resp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, " cpu_rvalid"}, cpu_rvalid, !e.host && !e.err);
      chk({tag, " host_rvalid"}, host_rvalid, e.host && !e.err);
      chk({tag, " cpu_err"}, cpu_err, !e.host && e.err);
      chk({tag, " host_err"}, host_err, e.host && e.err);
      if (!e.err && !e.host) begin
        chk({tag, " cpu_rdata"}, cpu_rdata, e.data);
        cpu_last = e.data; cpu_known = 1'b1;
        if (host_known) chk({tag, " host_rdata_hold"}, host_rdata, host_last);
      end else if (!e.err && e.host) begin
        chk({tag, " host_rdata"}, host_rdata, e.data);
        host_last = e.data; host_known = 1'b1;
        if (cpu_known) chk({tag, " cpu_rdata_hold"}, cpu_rdata, cpu_last);
      end
    end else begin
      chk({tag, " idle_rsp"}, {cpu_rvalid, host_rvalid, cpu_err, host_err}, 4'b0000);
    end
  endtask

  // One cycle: responses from last cycle, then this cycle's grant/memory command.
  task automatic run_cycle(input string tag, input bit ecg, input bit ehg, input bit een,
                           input bit ewe, input logic [3:0] ebe, input logic [31:0] ewd);
    logic [31:0] a;
    resp_t e;
    @(negedge clk);
    check_resp(tag);
    chk({tag, " gnt"}, {cpu_gnt, host_gnt}, {ecg, ehg});
    chk({tag, " mem_en/we"}, {mem_en, mem_we}, {een, een & ewe});
    chk({tag, " mem_be"}, mem_be, ebe);
    a = ehg ? host_addr : cpu_addr;
    if (een) chk({tag, " mem_widx"}, mem_widx, a[31:2]);
    if (een && ewe) chk({tag, " mem_wdata"}, mem_wdata, ewd);
    if ((ecg || ehg) && !een) begin
      e.host = ehg; e.err = 1'b1; e.data = '0;
      sb_q.push_back(e);
    end else if (een && !ewe) begin
      e.host = ehg; e.err = 1'b0; e.data = mem_fn(a[31:2]);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, " gnt"}, {cpu_gnt, host_gnt}, 2'b00);
    chk({tag, " rsp"}, {cpu_rvalid, host_rvalid, cpu_err, host_err}, 4'b0000);
    chk({tag, " mem_ctl"}, {mem_en, mem_we, mem_be}, 6'b0);
    chk({tag, " mem_widx"}, mem_widx, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, " host_rdata"}, host_rdata, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cpu_known = 1'b0; host_known = 1'b0; cpu_last = '0; host_last = '0;
    rst_n = 1'b0;
    set_cpu(1, 0, 2'b10, 32'h100, 32'h0);
    set_host(1, 0, 2'b10, 32'h200, 32'h0, 1);
    @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    set_cpu(0, 0, 2'b10, 32'h0, 32'h0);
    set_host(0, 0, 2'b10, 32'h0, 32'h0, 0);
    run_cycle("idle0", 0, 0, 0, 0, 4'h0, 32'h0);

    // cpu word load, then byte/half stores and a byte load
    set_cpu(1, 0, 2'b10, 32'h100, 32'h0);
    run_cycle("lw", 1, 0, 1, 0, 4'hF, 32'h0);
    set_cpu(1, 1, 2'b00, 32'h103, 32'h0000_00AB);
    run_cycle("sb", 1, 0, 1, 1, 4'b1000, 32'hABAB_ABAB);
    set_cpu(1, 1, 2'b01, 32'h102, 32'hFFFF_1234);
    run_cycle("sh", 1, 0, 1, 1, 4'b1100, 32'h1234_1234);
    set_cpu(1, 0, 2'b00, 32'h105, 32'h0);
    run_cycle("lb", 1, 0, 1, 0, 4'b0010, 32'h0);
    set_cpu(0, 0, 2'b10, 32'h0, 32'h0);
    run_cycle("idle1", 0, 0, 0, 0, 4'h0, 32'h0);

    // starvation: cpu keeps priority for 8 cycles, host wins the 9th
    set_host(1, 0, 2'b10, 32'h200, 32'h0, 0);
    for (int i = 0; i < 8; i++) begin
      set_cpu(1, 0, 2'b10, 32'h180 + 32'(4 * i), 32'h0);
      run_cycle("starve_cpu", 1, 0, 1, 0, 4'hF, 32'h0);
    end
    run_cycle("starve_host", 0, 1, 1, 0, 4'hF, 32'h0);
    run_cycle("wait_cleared", 1, 0, 1, 0, 4'hF, 32'h0);
    set_host(0, 0, 2'b10, 32'h0, 32'h0, 0);
    set_cpu(0, 0, 2'b10, 32'h0, 32'h0);
    run_cycle("idle2", 0, 0, 0, 0, 4'h0, 32'h0);

    // misaligned and illegal accesses
    set_cpu(1, 1, 2'b01, 32'h101, 32'h5555);
    run_cycle("sh_mis", 1, 0, 0, 0, 4'h0, 32'h0);
    set_cpu(1, 1, 2'b10, 32'h102, 32'h6666);
    run_cycle("sw_mis", 1, 0, 0, 0, 4'h0, 32'h0);
    set_cpu(0, 0, 2'b10, 32'h0, 32'h0);
    set_host(1, 0, 2'b11, 32'h300, 32'h0, 0);
    run_cycle("host_ill", 0, 1, 0, 0, 4'h0, 32'h0);
    set_host(0, 0, 2'b10, 32'h0, 32'h0, 0);
    run_cycle("idle3", 0, 0, 0, 0, 4'h0, 32'h0);

    // host burst with lock holds off a requesting cpu
    set_host(1, 1, 2'b10, 32'h300, 32'hC0DE_0000, 1);
    run_cycle("burst0", 0, 1, 1, 1, 4'hF, 32'hC0DE_0000);
    set_cpu(1, 0, 2'b10, 32'h104, 32'h0);
    for (int i = 1; i < 4; i++) begin
      set_host(1, 1, 2'b10, 32'h300 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1);
      run_cycle("burst", 0, 1, 1, 1, 4'hF, 32'hC0DE_0000 + 32'(i));
    end
    set_host(1, 1, 2'b10, 32'h310, 32'h0, 0);
    run_cycle("unlock", 1, 0, 1, 0, 4'hF, 32'h0);
    set_host(0, 0, 2'b10, 32'h0, 32'h0, 0);
    set_cpu(0, 0, 2'b10, 32'h0, 32'h0);
    run_cycle("idle4", 0, 0, 0, 0, 4'h0, 32'h0);

    // reset right after a host load grant: the response must vanish
    set_host(1, 0, 2'b10, 32'h400, 32'h0, 0);
    run_cycle("rst_ld", 0, 1, 1, 0, 4'hF, 32'h0);
    sb_q.delete();
    rst_n = 1'b0;
    set_cpu(1, 0, 2'b10, 32'h100, 32'h0);
    check_all_zero("rst_mid0");
    check_all_zero("rst_mid1");
    rst_n = 1'b1;
    cpu_known = 1'b0; host_known = 1'b0;
    set_cpu(0, 0, 2'b10, 32'h0, 32'h0);
    set_host(0, 0, 2'b10, 32'h0, 32'h0, 0);
    run_cycle("post_rst", 0, 0, 0, 0, 4'h0, 32'h0);
    run_cycle("post_rst2", 0, 0, 0, 0, 4'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
